multicycle_alu_controller: RTL
==============================

Name: multicycle_alu_controller

Overview:
- Multi-cycle control FSM that drives the 4-bit ALU control interface and the datapath strobes for the MIPS-subset CPU.
- It consumes the ALU zero flag and the memory ready handshake, and sequences fetch, decode, execute, memory and writeback.
- The ALU is the receiving end of alu_control. This block is the producing end, so its encodings must match the ALU exactly.

Parameters:
- ALU_CTRL_W, 4, width of alu_control.
- STATE_W, 4, width of the state register and the dbg_state port.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instruction bits [31:26] from the IR.
- funct  in  6  instruction bits [5:0] from the IR.
- zero  in  1  ALU flag; 1 when the ALU result is 0.
- mem_ready  in  1  memory completes the current read or write this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the IR.
- pc_en  out  1  load the PC.
- pc_source  out  2  next-PC select: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- alu_src_a  out  2  ALU a select: 0 = PC, 1 = reg A (rs), 2 = reg B (rt).
- alu_src_b  out  3  ALU b select: 0 = reg B, 1 = const 4, 2 = sext imm, 3 = sext imm<<2, 4 = zext imm, 5 = shamt.
- alu_control  out  4  ALU operation code.
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback data select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- illegal  out  1  sticky: unsupported opcode or funct was decoded.
- dbg_state  out  4  current state.

Behaviour:
- ALU control codes:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100
  - SLL 0101, SRL 0110, SRA 0111, LUI 1110
- States:
  - FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5
  - R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, ILLEGAL 15
- Output decode:
  - Outputs are decoded combinationally from the state (Moore), except pc_en in FETCH and BRANCH.
  - Any strobe not listed for a state is 0.
  - alu_control defaults to ADD.
- Reset:
  - rst high at a rising edge forces state = FETCH and illegal = 0.
  - While rst is high, all strobes are forced to 0 (mem_read, mem_write, ir_write, pc_en, reg_write).
  - Reset mid-instruction abandons that instruction with no write.
- FETCH:
  - mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, ADD, pc_source = 0.
  - Stays in FETCH while mem_ready = 0.
  - On mem_ready = 1: ir_write = 1, pc_en = 1, go to DECODE.
- DECODE:
  - alu_src_a = 0, alu_src_b = 3, ADD (branch target into ALUOut).
  - Next state by opcode:
    - 000000 → R_EXEC
    - 100011 (lw) or 101011 (sw) → MEM_ADDR
    - 000100 (beq) or 000101 (bne) → BRANCH
    - 000010 (j) → JUMP
    - 001000 (addi), 001100 (andi), 001101 (ori), 001110 (xori), 001111 (lui) → I_EXEC
    - any other opcode → ILLEGAL
  - R-type with an unsupported funct → ILLEGAL.
- MEM_ADDR:
  - alu_src_a = 1, alu_src_b = 2, ADD.
  - Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD:
  - mem_read = 1, iord = 1.
  - Holds until mem_ready, then → MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0, → FETCH.
- MEM_WR:
  - mem_write = 1, iord = 1.
  - Holds until mem_ready, then → FETCH.
- R_EXEC, add/sub/and/or/xor:
  - alu_src_a = 1, alu_src_b = 0.
  - funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR.
- R_EXEC, shifts:
  - alu_src_a = 2, alu_src_b = 5.
  - funct 000000 SLL, 000010 SRL, 000011 SRA.
- R_EXEC → R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0, → FETCH.
- BRANCH:
  - alu_src_a = 1, alu_src_b = 0, SUB, pc_source = 1.
  - pc_en = zero for beq, pc_en = ~zero for bne.
  - → FETCH.
- JUMP: pc_source = 2, pc_en = 1, → FETCH.
- I_EXEC:
  - alu_src_a = 1.
  - addi: alu_src_b = 2, ADD.
  - andi, ori, xori: alu_src_b = 4, AND / OR / XOR.
  - lui: alu_src_b = 4, LUI.
  - → I_WB.
- I_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0, → FETCH.
- ILLEGAL: illegal = 1, all strobes 0, remains in ILLEGAL until rst.
- Latency in cycles, with zero memory wait:
  - branch and j: 3
  - R-type, I-type, sw: 4
  - lw: 5
  - Each cycle with mem_ready = 0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- Memory requests: mem_read and mem_write are never both 1 in the same cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU op constants, which the ALU must also use.
  - State encodings.
  - Opcode and funct constants.
  - The alu_src_a, alu_src_b and pc_source select encodings.
- One natural sub-module: alu_op_decoder. It is combinational and maps opcode and funct to the ALU code plus an illegal bit. It is used by the FSM's R_EXEC and I_EXEC states and by the DECODE-state illegal check.

Test Plan:
- Reset, then add (opcode 0, funct 0x20) with mem_ready held at 1:
  - states 0 → 1 → 6 → 7 → 0
  - alu_control = 0000 in R_EXEC
  - reg_write = 1 with reg_dst = 1 at cycle 4
- lw (0x23) with mem_ready low for 2 cycles in MEM_RD:
  - MEM_RD lasts 3 cycles
  - MEM_WB asserts reg_write and mem_to_reg
  - total 7 cycles
- beq:
  - zero = 1 → pc_en = 1 with pc_source = 1 in BRANCH
  - repeat with bne and zero = 1 → pc_en = 0
  - alu_control = 0001 in BRANCH
- sra (funct 0x03) → alu_control = 0111, alu_src_a = 2, alu_src_b = 5.
- lui (0x0F) → alu_control = 1110, alu_src_b = 4.
- Opcode 0x3F → ILLEGAL, illegal = 1 and sticky, no strobes. Asserting rst for one cycle returns the FSM to FETCH with illegal = 0.
- Assert rst during MEM_WR with mem_ready = 0:
  - mem_write = 0 immediately
  - state = FETCH after the edge
  - no reg_write occurs

Source files
------------

// File: rtl/multicycle_alu_controller_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared encodings for the MIPS-subset multicycle CPU: ALU ops,
//           controller states, opcode/funct values and datapath selects.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  // ALU operation codes; the ALU decodes exactly these values.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_LUI = 4'b1110;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_R_EXEC   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_I_EXEC   = 4'd10,
    ST_I_WB     = 4'd11,
    ST_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_REG_A = 2'd1;
  localparam logic [1:0] SRCA_REG_B = 2'd2;

  localparam logic [2:0] SRCB_REG_B   = 3'd0;
  localparam logic [2:0] SRCB_FOUR    = 3'd1;
  localparam logic [2:0] SRCB_SEXT    = 3'd2;
  localparam logic [2:0] SRCB_SEXT_S2 = 3'd3;
  localparam logic [2:0] SRCB_ZEXT    = 3'd4;
  localparam logic [2:0] SRCB_SHAMT   = 3'd5;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  function automatic logic is_shift(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_alu_controller_if.sv
// ============================================================================
// Module  : multicycle_alu_controller_if
// Brief   : Controller <-> datapath/memory bundle. master = controller side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_alu_controller_if #(
  parameter int ALU_CTRL_W = 4,
  parameter int STATE_W    = 4
);
  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic                  zero;
  logic                  mem_ready;
  logic                  mem_read;
  logic                  mem_write;
  logic                  iord;
  logic                  ir_write;
  logic                  pc_en;
  logic [1:0]            pc_source;
  logic [1:0]            alu_src_a;
  logic [2:0]            alu_src_b;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  reg_dst;
  logic                  mem_to_reg;
  logic                  reg_write;
  logic                  illegal;
  logic [STATE_W-1:0]    dbg_state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_en, pc_source,
           alu_src_a, alu_src_b, alu_control, reg_dst, mem_to_reg,
           reg_write, illegal, dbg_state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_en, pc_source,
           alu_src_a, alu_src_b, alu_control, reg_dst, mem_to_reg,
           reg_write, illegal, dbg_state
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_alu_controller_alu_op_decoder.sv
// ============================================================================
// Module  : alu_op_decoder
// Brief   : Combinational opcode/funct to ALU-op map with unsupported flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_decoder
  import cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          default: illegal = 1'b1;
        endcase
      end
      OP_LW, OP_SW, OP_J, OP_ADDI: alu_op = ALU_ADD;
      OP_BEQ, OP_BNE:              alu_op = ALU_SUB;
      OP_ANDI:                     alu_op = ALU_AND;
      OP_ORI:                      alu_op = ALU_OR;
      OP_XORI:                     alu_op = ALU_XOR;
      OP_LUI:                      alu_op = ALU_LUI;
      default:                     illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_alu_controller.sv
// ============================================================================
// Module  : multicycle_alu_controller
// Brief   : Moore control FSM sequencing fetch/decode/execute/mem/writeback.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_alu_controller
  import cpu_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int STATE_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  multicycle_alu_controller_if.master bus
);

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [3:0] dec_alu_op;
  logic       dec_illegal;

  logic       mem_read, mem_write, iord, ir_write, pc_en;
  logic       reg_dst, mem_to_reg, reg_write;
  logic [1:0] pc_source, alu_src_a;
  logic [2:0] alu_src_b;
  logic [3:0] alu_control;

  alu_op_decoder u_alu_op_decoder (
    .opcode  (bus.opcode),
    .funct   (bus.funct),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:    if (bus.mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_illegal) begin
          state_d = ST_ILLEGAL;
        end else begin
          case (bus.opcode)
            OP_RTYPE:                                   state_d = ST_R_EXEC;
            OP_LW, OP_SW:                               state_d = ST_MEM_ADDR;
            OP_BEQ, OP_BNE:                             state_d = ST_BRANCH;
            OP_J:                                       state_d = ST_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:  state_d = ST_I_EXEC;
            default:                                    state_d = ST_ILLEGAL;
          endcase
        end
      end
      ST_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (bus.mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:   state_d = ST_FETCH;
      ST_MEM_WR:   if (bus.mem_ready) state_d = ST_FETCH;
      ST_R_EXEC:   state_d = ST_R_WB;
      ST_R_WB:     state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      ST_I_EXEC:   state_d = ST_I_WB;
      ST_I_WB:     state_d = ST_FETCH;
      ST_ILLEGAL:  state_d = ST_ILLEGAL;
      default:     state_d = ST_ILLEGAL;
    endcase
    illegal_d = illegal_q | (state_d == ST_ILLEGAL);
  end

  // Moore decode; pc_en in FETCH/BRANCH also depends on mem_ready/zero.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_source   = PCSRC_ALU;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_REG_B;
    alu_control = ALU_ADD;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = bus.mem_ready;
        pc_en     = bus.mem_ready;
      end
      ST_DECODE:   alu_src_b = SRCB_SEXT_S2;
      ST_MEM_ADDR: begin
        alu_src_a = SRCA_REG_A;
        alu_src_b = SRCB_SEXT;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      ST_R_EXEC: begin
        alu_control = dec_alu_op;
        if (is_shift(bus.funct)) begin
          alu_src_a = SRCA_REG_B;
          alu_src_b = SRCB_SHAMT;
        end else begin
          alu_src_a = SRCA_REG_A;
          alu_src_b = SRCB_REG_B;
        end
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a   = SRCA_REG_A;
        alu_control = ALU_SUB;
        pc_source   = PCSRC_ALUOUT;
        pc_en       = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
      end
      ST_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_en     = 1'b1;
      end
      ST_I_EXEC: begin
        alu_src_a   = SRCA_REG_A;
        alu_src_b   = (bus.opcode == OP_ADDI) ? SRCB_SEXT : SRCB_ZEXT;
        alu_control = dec_alu_op;
      end
      ST_I_WB:     reg_write = 1'b1;
      default: ;
    endcase
    if (rst) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.iord        = iord;
  assign bus.ir_write    = ir_write;
  assign bus.pc_en       = pc_en;
  assign bus.pc_source   = pc_source;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.alu_control = ALU_CTRL_W'(alu_control);
  assign bus.reg_dst     = reg_dst;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.reg_write   = reg_write;
  assign bus.illegal     = illegal_q;
  assign bus.dbg_state   = STATE_W'(state_q);

endmodule

`default_nettype wire
